multicycle_control: RTL and testbench

//  Multi-cycle sequencer for the shared-ALU/shared-memory datapath: one FSM drives fetch, decode,

---
 rtl/mc_ctrl_pkg.sv | 45 ++++
 rtl/multicycle_control.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: opcodes, FSM states,
// datapath mux/ALU codes and opcode classification.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BVF   = 6'h05;
  localparam logic [5:0] OP_BEN   = 6'h06;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_ALU   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10
  } state_e;

  typedef enum logic [3:0] {
    OC_R, OC_ADDI, OC_LW, OC_SW, OC_BEQ, OC_BVF, OC_BEN, OC_J, OC_ILL
  } op_class_e;

  localparam logic [1:0] ASB_RT     = 2'd0;
  localparam logic [1:0] ASB_FOUR   = 2'd1;
  localparam logic [1:0] ASB_IMM    = 2'd2;
  localparam logic [1:0] ASB_IMM_SH = 2'd3;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;

endpackage

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback sequencing,
// branch resolution from CPSR flags and retired-instruction counting.
// Optional MEM_WAIT_EN: FETCH/MEM_RD/MEM_WR stall until mem_ready.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OP_W   = 6,
  parameter int unsigned RCNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   opcode,
  input  logic              alu_zero,
  input  logic              cpsr_n,
  input  logic              cpsr_v,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              iord,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic              regdest,
  output logic              memtoreg,
  output logic              regwrite,
  output logic              alusrc_a,
  output logic [1:0]        alusrc_b,
  output logic [1:0]        aluop,
  output logic [1:0]        pcsource,
  output logic              cpsr_update,
  output logic              cpsr_reset,
  output logic              illegal_op,
  output logic [RCNT_W-1:0] retired_cnt
);

  state_e    state, next_state;
  op_class_e op_class;
  logic      run;
  logic      mem_ok;
  logic      retire;

`ifdef MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  always_comb begin
    op_class = OC_ILL;
    case (opcode)
      OP_W'(OP_RTYPE): op_class = OC_R;
      OP_W'(OP_ADDI):  op_class = OC_ADDI;
      OP_W'(OP_LW):    op_class = OC_LW;
      OP_W'(OP_SW):    op_class = OC_SW;
      OP_W'(OP_BEQ):   op_class = OC_BEQ;
      OP_W'(OP_BVF):   op_class = OC_BVF;
      OP_W'(OP_BEN):   op_class = OC_BEN;
      OP_W'(OP_J):     op_class = OC_J;
      default:         op_class = OC_ILL;
    endcase
  end

  // run holds the FSM idle (all controls low) for the first cycle after reset
  // release, so FETCH strobes only appear once the clock has ticked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      run   <= 1'b0;
    end else begin
      state <= next_state;
      run   <= 1'b1;
    end
  end

  always_comb begin
    next_state  = state;
    pc_write    = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    regdest     = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    alusrc_a    = 1'b0;
    alusrc_b    = ASB_RT;
    aluop       = ALU_ADD;
    pcsource    = PCS_ALU;
    cpsr_update = 1'b0;
    cpsr_reset  = 1'b0;
    illegal_op  = 1'b0;
    if (run) begin
      case (state)
        S_FETCH: begin
          mem_read = 1'b1;
          alusrc_b = ASB_FOUR;
          pcsource = PCS_ALU;
          pc_write = mem_ok;
          ir_write = mem_ok;
          if (mem_ok) next_state = S_DECODE;
        end
        S_DECODE: begin
          alusrc_b = ASB_IMM_SH;
          case (op_class)
            OC_R:                   next_state = S_EXEC_R;
            OC_ADDI:                next_state = S_EXEC_I;
            OC_LW, OC_SW:           next_state = S_MEM_ADDR;
            OC_BEQ, OC_BVF, OC_BEN: next_state = S_BRANCH;
            OC_J:                   next_state = S_JUMP;
            default: begin
              illegal_op = 1'b1;
              next_state = S_FETCH;
            end
          endcase
        end
        S_EXEC_R: begin
          alusrc_a    = 1'b1;
          alusrc_b    = ASB_RT;
          aluop       = ALU_FUNCT;
          cpsr_update = 1'b1;
          next_state  = S_WB_ALU;
        end
        S_EXEC_I: begin
          alusrc_a    = 1'b1;
          alusrc_b    = ASB_IMM;
          aluop       = ALU_ADD;
          cpsr_update = 1'b1;
          next_state  = S_WB_ALU;
        end
        S_WB_ALU: begin
          regwrite   = 1'b1;
          regdest    = (op_class == OC_R);
          next_state = S_FETCH;
        end
        S_MEM_ADDR: begin
          alusrc_a    = 1'b1;
          alusrc_b    = ASB_IMM;
          aluop       = ALU_ADD;
          cpsr_update = 1'b1;
          next_state  = (op_class == OC_LW) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          if (mem_ok) next_state = S_WB_MEM;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          if (mem_ok) next_state = S_FETCH;
        end
        S_WB_MEM: begin
          regwrite   = 1'b1;
          memtoreg   = 1'b1;
          next_state = S_FETCH;
        end
        S_BRANCH: begin
          alusrc_a   = 1'b1;
          alusrc_b   = ASB_RT;
          aluop      = ALU_SUB;
          pcsource   = PCS_ALUOUT;
          cpsr_reset = 1'b1;
          pc_write   = ((op_class == OC_BEQ) && alu_zero) ||
                       ((op_class == OC_BVF) && cpsr_v)   ||
                       ((op_class == OC_BEN) && cpsr_n);
          next_state = S_FETCH;
        end
        S_JUMP: begin
          pcsource   = PCS_JUMP;
          pc_write   = 1'b1;
          cpsr_reset = 1'b1;
          next_state = S_FETCH;
        end
        default: next_state = S_FETCH;
      endcase
    end
  end

  always_comb begin
    retire = 1'b0;
    if (run) begin
      case (state)
        S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: retire = 1'b1;
        S_MEM_WR:                             retire = mem_ok;
        default:                              retire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_cnt <= '0;
    else if (retire) retired_cnt <= retired_cnt + RCNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control; a second instance with a
// 2-bit counter tracks the main count modulo 4 to exercise counter wrap.
module tb_multicycle_control;

  logic        clk, rst_n;
  logic [5:0]  opcode;
  logic        alu_zero, cpsr_n, cpsr_v, mem_ready;
  logic        pc_write, iord, mem_read, mem_write, ir_write, regdest, memtoreg, regwrite, alusrc_a;
  logic [1:0]  alusrc_b, aluop, pcsource;
  logic        cpsr_update, cpsr_reset, illegal_op;
  logic [31:0] retired_cnt;
  logic        w_pc_write, w_iord, w_mem_read, w_mem_write, w_ir_write, w_regdest, w_memtoreg;
  logic        w_regwrite, w_alusrc_a, w_cpsr_update, w_cpsr_reset, w_illegal_op;
  logic [1:0]  w_alusrc_b, w_aluop, w_pcsource, w_cnt;
  logic [17:0] act, w_act;

  int unsigned total = 0;
  int unsigned bad   = 0;

  multicycle_control #(.OP_W(6), .RCNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero), .cpsr_n(cpsr_n),
    .cpsr_v(cpsr_v), .mem_ready(mem_ready), .pc_write(pc_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .regdest(regdest),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b),
    .aluop(aluop), .pcsource(pcsource), .cpsr_update(cpsr_update), .cpsr_reset(cpsr_reset),
    .illegal_op(illegal_op), .retired_cnt(retired_cnt)
  );

  multicycle_control #(.OP_W(6), .RCNT_W(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero), .cpsr_n(cpsr_n),
    .cpsr_v(cpsr_v), .mem_ready(mem_ready), .pc_write(w_pc_write), .iord(w_iord),
    .mem_read(w_mem_read), .mem_write(w_mem_write), .ir_write(w_ir_write), .regdest(w_regdest),
    .memtoreg(w_memtoreg), .regwrite(w_regwrite), .alusrc_a(w_alusrc_a), .alusrc_b(w_alusrc_b),
    .aluop(w_aluop), .pcsource(w_pcsource), .cpsr_update(w_cpsr_update),
    .cpsr_reset(w_cpsr_reset), .illegal_op(w_illegal_op), .retired_cnt(w_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act   = {pc_write, iord, mem_read, mem_write, ir_write, regdest, memtoreg, regwrite,
                  alusrc_a, alusrc_b, aluop, pcsource, cpsr_update, cpsr_reset, illegal_op};
  assign w_act = {w_pc_write, w_iord, w_mem_read, w_mem_write, w_ir_write, w_regdest, w_memtoreg,
                  w_regwrite, w_alusrc_a, w_alusrc_b, w_aluop, w_pcsource, w_cpsr_update,
                  w_cpsr_reset, w_illegal_op};

  function automatic logic [17:0] ctl(input logic pcw, io, mr, mw, irw, rd, m2r, rw, asa,
                                      input logic [1:0] asb, aop, pcs,
                                      input logic cu, cr, ill);
    return {pcw, io, mr, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, cu, cr, ill};
  endfunction

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        z, n, v;
    logic [17:0] exp;
    int unsigned cnt;
  } vec_t;

  vec_t vecs[$];

  logic [17:0] F, D, DI, XR, XI, WR, WI, MA, MR, MW, WM, BT, BN, JP;

  task automatic add(input string name, input logic [5:0] op, input logic z, n, v,
                     input logic [17:0] exp, input int unsigned cnt);
    vec_t t;
    t.name = name; t.op = op; t.z = z; t.n = n; t.v = v; t.exp = exp; t.cnt = cnt;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [17:0] exp, input int unsigned ecnt);
    logic [31:0] e32;
    e32 = ecnt;
    total++;
    if (act !== exp || w_act !== exp || retired_cnt !== e32 || w_cnt !== e32[1:0]) begin
      bad++;
      $display("FAIL %s: ctl=%h wrap_ctl=%h cnt=%0d wrap_cnt=%0d, required ctl=%h cnt=%0d wrap_cnt=%0d",
               name, act, w_act, retired_cnt, w_cnt, exp, e32, e32[1:0]);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic z, n, v, mr);
    @(negedge clk);
    opcode = op; alu_zero = z; cpsr_n = n; cpsr_v = v; mem_ready = mr;
    #1;
  endtask

  initial begin
    //          pcw io mr mw irw rd m2r rw asa asb   aop   pcs   cu cr ill
    F  = ctl(1, 0, 1, 0, 1, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 0, 0, 0);
    D  = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 2'd0, 0, 0, 0);
    DI = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 2'd0, 0, 0, 1);
    XR = ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 2'd0, 1, 0, 0);
    XI = ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 2'd0, 1, 0, 0);
    WR = ctl(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0);
    WI = ctl(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0);
    MA = ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 2'd0, 1, 0, 0);
    MR = ctl(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0);
    MW = ctl(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0);
    WM = ctl(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0);
    BT = ctl(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 2'd1, 0, 1, 0);
    BN = ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 2'd1, 0, 1, 0);
    JP = ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 0, 1, 0);

    // R, lw, bvf taken/not, ben taken, beq taken/not, j, illegal, sw, addi
    add("r_fetch", 6'h00, 0, 0, 0, F, 0);  add("r_dec", 6'h00, 0, 0, 0, D, 0);
    add("r_exec", 6'h00, 0, 0, 0, XR, 0);  add("r_wb", 6'h00, 0, 0, 0, WR, 0);
    add("lw_fetch", 6'h23, 0, 0, 0, F, 1); add("lw_dec", 6'h23, 0, 0, 0, D, 1);
    add("lw_addr", 6'h23, 0, 0, 0, MA, 1); add("lw_rd", 6'h23, 0, 0, 0, MR, 1);
    add("lw_wb", 6'h23, 0, 0, 0, WM, 1);
    add("bvf1_fetch", 6'h05, 0, 0, 1, F, 2); add("bvf1_dec", 6'h05, 0, 0, 1, D, 2);
    add("bvf1_br", 6'h05, 0, 0, 1, BT, 2);
    add("bvf0_fetch", 6'h05, 1, 1, 0, F, 3); add("bvf0_dec", 6'h05, 1, 1, 0, D, 3);
    add("bvf0_br", 6'h05, 1, 1, 0, BN, 3);
    add("ben_fetch", 6'h06, 0, 1, 0, F, 4); add("ben_dec", 6'h06, 0, 1, 0, D, 4);
    add("ben_br", 6'h06, 0, 1, 0, BT, 4);
    add("beq1_fetch", 6'h04, 1, 0, 0, F, 5); add("beq1_dec", 6'h04, 1, 0, 0, D, 5);
    add("beq1_br", 6'h04, 1, 0, 0, BT, 5);
    add("beq0_fetch", 6'h04, 0, 1, 1, F, 6); add("beq0_dec", 6'h04, 0, 1, 1, D, 6);
    add("beq0_br", 6'h04, 0, 1, 1, BN, 6);
    add("j_fetch", 6'h02, 0, 0, 0, F, 7);  add("j_dec", 6'h02, 0, 0, 0, D, 7);
    add("j_jump", 6'h02, 0, 0, 0, JP, 7);
    add("ill_fetch", 6'h3F, 0, 0, 0, F, 8); add("ill_dec", 6'h3F, 0, 0, 0, DI, 8);
    add("sw_fetch", 6'h2B, 0, 0, 0, F, 8); add("sw_dec", 6'h2B, 0, 0, 0, D, 8);
    add("sw_addr", 6'h2B, 0, 0, 0, MA, 8); add("sw_wr", 6'h2B, 0, 0, 0, MW, 8);
    add("addi_fetch", 6'h08, 0, 0, 0, F, 9); add("addi_dec", 6'h08, 0, 0, 0, D, 9);
    add("addi_exec", 6'h08, 0, 0, 0, XI, 9); add("addi_wb", 6'h08, 0, 0, 0, WI, 9);
    add("final_fetch", 6'h00, 0, 0, 0, F, 10);

    rst_n = 1'b0; opcode = '0; alu_zero = 1'b0; cpsr_n = 1'b0; cpsr_v = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 check("reset", '0, 0);

    // Reset asserted mid-EXEC_R after one retired instruction
    @(negedge clk); rst_n = 1'b1; #1 check("idle_after_rst", '0, 0);
    drive(6'h00, 0, 0, 0, 1); check("pre_fetch", F, 0);
    drive(6'h00, 0, 0, 0, 1); check("pre_dec", D, 0);
    drive(6'h00, 0, 0, 0, 1); check("pre_exec", XR, 0);
    drive(6'h00, 0, 0, 0, 1); check("pre_wb", WR, 0);
    drive(6'h00, 0, 0, 0, 1); check("pre2_fetch", F, 1);
    drive(6'h00, 0, 0, 0, 1); check("pre2_dec", D, 1);
    drive(6'h00, 0, 0, 0, 1); check("pre2_exec", XR, 1);
    rst_n = 1'b0; #1 check("rst_mid_exec", '0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; #1 check("idle_after_rst2", '0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].z, vecs[i].n, vecs[i].v, 1'b1);
      check(vecs[i].name, vecs[i].exp, vecs[i].cnt);
    end

`ifdef MEM_WAIT_EN
    drive(6'h2B, 0, 0, 0, 1); check("wsw_dec", D, 10);
    drive(6'h2B, 0, 0, 0, 1); check("wsw_addr", MA, 10);
    for (int k = 0; k < 3; k++) begin
      drive(6'h2B, 0, 0, 0, 0); check("wsw_wait", MW, 10);
    end
    drive(6'h2B, 0, 0, 0, 1); check("wsw_done", MW, 10);
    drive(6'h00, 0, 0, 0, 0);
    check("wsw_fetch_stall", ctl(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 0, 0, 0), 11);
    drive(6'h00, 0, 0, 0, 1); check("wsw_fetch_go", F, 11);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
